comma_word_aligner: RTL and testbench

Receive-side word aligner between the serial line and the 8b/10b decoder. It runs on the bit clock and watches the incoming serial stream for the K28.5 comma in either running disparity. It fixes the 10-bit word boundary from where the comma falls, then emits aligned 10-bit code groups with a one-cycle valid strobe. A hunt/check/locked state machine qualifies the alignment and reports lock.

---
 rtl/comma_word_aligner.sv | 134 +++++++++++++
 tb/tb_comma_word_aligner.sv | 445 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/comma_word_aligner.sv
// Bit-clock K28.5 comma word aligner with hunt/check/locked qualification.
// Optional off-boundary comma counter (ErrCnt) enabled by ALIGN_ERR_CNT_EN.
module comma_word_aligner #(
  parameter logic [9:0] COMMA_P    = 10'h17C,
  parameter int         LOCK_COUNT = 3,
  parameter int         LOSS_COUNT = 4
) (
  input  logic       BitCLK,
  input  logic       Reset_n,
  input  logic       Serial,
  output logic [9:0] RxParallel_10,
  output logic       RxValid,
  output logic       CommaDet,
  output logic       Locked
`ifdef ALIGN_ERR_CNT_EN
  ,
  output logic [7:0] ErrCnt
`endif
);

  typedef enum logic [1:0] {HUNT, CHECK, LOCKED} state_t;

  localparam logic [3:0] LOCK_C = 4'(LOCK_COUNT);
  localparam logic [3:0] LOSS_C = 4'(LOSS_COUNT);

  state_t     state, state_next;
  logic [9:0] sh, win;
  logic [3:0] ph, good_cnt, bad_cnt;
  logic       comma_hit, boundary;
  logic       emit, realign, good_load, good_inc, good_clr, bad_clr, bad_inc;

  // Window includes the bit arriving this edge, so a word is emitted with no extra latency.
  assign win       = {Serial, sh[9:1]};
  assign comma_hit = (win == COMMA_P) || (win == ~COMMA_P);
  assign boundary  = (ph == 4'd9);

  always_ff @(posedge BitCLK or negedge Reset_n) begin
    if (!Reset_n) state <= HUNT;
    else          state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      HUNT:    if (comma_hit) state_next = CHECK;
      CHECK:   if (comma_hit && boundary && (good_cnt + 4'd1 == LOCK_C)) state_next = LOCKED;
      LOCKED:  if (comma_hit && !boundary && (bad_cnt + 4'd1 == LOSS_C)) state_next = HUNT;
      default: state_next = HUNT;
    endcase
  end

  always_comb begin
    emit      = 1'b0;
    realign   = 1'b0;
    good_load = 1'b0;
    good_inc  = 1'b0;
    good_clr  = 1'b0;
    bad_clr   = 1'b0;
    bad_inc   = 1'b0;
    case (state)
      HUNT: begin
        if (comma_hit) begin
          realign   = 1'b1;
          emit      = 1'b1;
          good_load = 1'b1;
        end
      end
      CHECK: begin
        if (comma_hit && boundary) begin
          emit     = 1'b1;
          good_inc = 1'b1;
          bad_clr  = (good_cnt + 4'd1 == LOCK_C);
        end else if (comma_hit) begin
          realign   = 1'b1;
          emit      = 1'b1;
          good_load = 1'b1;
        end else if (boundary) begin
          emit = 1'b1;
        end
      end
      LOCKED: begin
        // Off-boundary commas are tolerated up to LOSS_COUNT without moving the boundary.
        if (boundary) begin
          emit    = 1'b1;
          bad_clr = comma_hit;
        end else if (comma_hit) begin
          bad_inc  = 1'b1;
          good_clr = (bad_cnt + 4'd1 == LOSS_C);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge BitCLK or negedge Reset_n) begin
    if (!Reset_n) begin
      sh            <= '0;
      ph            <= '0;
      good_cnt      <= '0;
      bad_cnt       <= '0;
      RxParallel_10 <= '0;
      RxValid       <= 1'b0;
      CommaDet      <= 1'b0;
      Locked        <= 1'b0;
    end else begin
      sh <= win;
      if (realign || boundary) ph <= 4'd0;
      else                     ph <= ph + 4'd1;

      if (good_load)     good_cnt <= 4'd1;
      else if (good_inc) good_cnt <= good_cnt + 4'd1;
      else if (good_clr) good_cnt <= 4'd0;

      if (bad_clr)      bad_cnt <= 4'd0;
      else if (bad_inc) bad_cnt <= bad_cnt + 4'd1;

      if (emit) RxParallel_10 <= win;
      RxValid  <= emit;
      CommaDet <= emit && comma_hit;
      Locked   <= (state_next == LOCKED);
    end
  end

`ifdef ALIGN_ERR_CNT_EN
  logic err_hit;
  assign err_hit = comma_hit && !boundary && (state != HUNT);

  always_ff @(posedge BitCLK or negedge Reset_n) begin
    if (!Reset_n)                       ErrCnt <= '0;
    else if (err_hit && ErrCnt != 8'hFF) ErrCnt <= ErrCnt + 8'd1;
  end
`endif

endmodule

// File: tb/tb_comma_word_aligner.sv
// Self-checking bench for comma_word_aligner: bit-history reference model plus directed scenarios.
// ErrCnt checks are compiled in when ALIGN_ERR_CNT_EN is defined.
module tb_comma_word_aligner;

  localparam logic [9:0] COMMA = 10'h17C;
  localparam int LOCK_N = 3;
  localparam int LOSS_N = 4;

  logic       BitCLK = 1'b0;
  logic       Reset_n = 1'b0;
  logic       Serial = 1'b0;
  logic [9:0] RxParallel_10;
  logic       RxValid, CommaDet, Locked;
  logic [7:0] err_obs;
`ifdef ALIGN_ERR_CNT_EN
  logic [7:0] ErrCnt;
  assign err_obs = ErrCnt;
`else
  assign err_obs = 8'h00;
`endif

  comma_word_aligner #(.COMMA_P(COMMA), .LOCK_COUNT(LOCK_N), .LOSS_COUNT(LOSS_N)) dut (
    .BitCLK(BitCLK),
    .Reset_n(Reset_n),
    .Serial(Serial),
    .RxParallel_10(RxParallel_10),
    .RxValid(RxValid),
    .CommaDet(CommaDet),
    .Locked(Locked)
`ifdef ALIGN_ERR_CNT_EN
    ,
    .ErrCnt(ErrCnt)
`endif
  );

  always #5 BitCLK = ~BitCLK;

  logic [20:0] obs;
  assign obs = {RxValid, CommaDet, Locked, RxParallel_10, err_obs};

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: keeps the full bit history since reset; a boundary is any edge
  // a multiple of ten after the last alignment point.
  bit         m_hist[$];
  int         m_k, m_ref, m_state, m_good, m_bad, m_err;
  logic [9:0] m_par;
  bit         m_valid, m_cdet;
  bit         stim[$];

  task automatic model_reset();
    m_hist.delete();
    m_k = 0; m_ref = 0; m_state = 0; m_good = 0; m_bad = 0; m_err = 0;
    m_par = '0; m_valid = 0; m_cdet = 0;
  endtask

  task automatic model_step(input bit b);
    logic [9:0] w;
    bit hit, bnd;
    m_hist.push_back(b);
    m_k++;
    for (int j = 0; j < 10; j++) begin
      int idx;
      idx = m_k - 10 + j;
      w[j] = (idx >= 0) ? m_hist[idx] : 1'b0;
    end
    hit = (w == COMMA) || (w == ~COMMA);
    bnd = ((m_k - m_ref) % 10) == 0;
    m_valid = 0;
    if (m_state == 0) begin
      if (hit) begin m_ref = m_k; m_valid = 1; m_good = 1; m_state = 1; end
    end else if (m_state == 1) begin
      if (hit && bnd) begin
        m_valid = 1; m_good++;
        if (m_good == LOCK_N) begin m_state = 2; m_bad = 0; end
      end else if (hit) begin
        m_ref = m_k; m_valid = 1; m_good = 1; m_err++;
      end else if (bnd) m_valid = 1;
    end else begin
      if (bnd) begin
        m_valid = 1;
        if (hit) m_bad = 0;
      end else if (hit) begin
        m_bad++; m_err++;
        if (m_bad == LOSS_N) begin m_state = 0; m_good = 0; end
      end
    end
    m_cdet = m_valid && hit;
    if (m_valid) m_par = w;
  endtask

  function automatic logic [20:0] exp_vec();
    logic [7:0] e;
`ifdef ALIGN_ERR_CNT_EN
    e = (m_err > 255) ? 8'hFF : 8'(m_err);
`else
    e = 8'h00;
`endif
    return {m_valid, m_cdet, (m_state == 2), m_par, e};
  endfunction

  task automatic drive_bit(input bit b);
    Serial = b;
    @(posedge BitCLK);
    #1;
    model_step(b);
  endtask

  task automatic do_reset();
    @(posedge BitCLK);
    #2 Reset_n = 1'b0;
    repeat (3) begin
      Serial = 1'($urandom);
      @(posedge BitCLK);
    end
    #2 Reset_n = 1'b1;
    model_reset();
  endtask

  task automatic push_word(input logic [9:0] w);
    for (int j = 0; j < 10; j++) stim.push_back(w[j]);
  endtask

  task automatic push_alt(input int n);
    for (int j = 0; j < n; j++) stim.push_back(((j % 2) == 0) ? 1'b1 : 1'b0);
  endtask

  // 20 bits holding a comma four bits past a boundary; keeps the ten-bit phase.
  task automatic push_unit();
    push_alt(4);
    push_word(COMMA);
    push_alt(6);
  endtask

  function automatic bit prefix_ok(input logic [6:0] r);
    bit seq[17];
    logic [9:0] w;
    for (int j = 0; j < 7; j++) seq[j] = r[j];
    for (int j = 0; j < 10; j++) seq[7 + j] = COMMA[j];
    for (int e = 1; e <= 16; e++) begin
      for (int j = 0; j < 10; j++) begin
        int idx;
        idx = e - 10 + j;
        w[j] = (idx >= 0) ? seq[idx] : 1'b0;
      end
      if (w == COMMA || w == ~COMMA) return 0;
    end
    return 1;
  endfunction

  task automatic test_reset();
    for (int i = 0; i < 5; i++) begin
      Serial = 1'($urandom);
      @(posedge BitCLK);
      #1;
      n_checks++;
      if (obs !== 21'h0) begin
        n_errors++;
        $display("FAIL reset_hold cycle=%0d got=%h exp=%h", i, obs, 21'h0);
      end
    end
    #1 Reset_n = 1'b1;
    model_reset();
    stim.delete();
    push_alt(20);
    repeat (LOCK_N) push_word(COMMA);
    for (int i = 0; i < stim.size(); i++) begin
      drive_bit(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL reset_release edge=%0d got=%h exp=%h", m_k, obs, exp_vec());
      end
      if (m_k < 30) begin
        n_checks++;
        if (RxValid !== 1'b0) begin
          n_errors++;
          $display("FAIL reset_no_valid edge=%0d got=%b exp=0", m_k, RxValid);
        end
      end
    end
    n_checks++;
    if (Locked !== 1'b1) begin
      n_errors++;
      $display("FAIL reset_prelock got=%b exp=1", Locked);
    end
    #2 Reset_n = 1'b0;
    #1;
    n_checks++;
    if (obs !== 21'h0) begin
      n_errors++;
      $display("FAIL reset_async got=%h exp=%h", obs, 21'h0);
    end
    repeat (2) @(posedge BitCLK);
    #2 Reset_n = 1'b1;
    model_reset();
    $display("test_reset done");
  endtask

  task automatic test_acquire();
    logic [6:0] r;
    int first_v, lock_edge, n_str;
    do r = 7'($urandom); while (!prefix_ok(r));
    do_reset();
    stim.delete();
    for (int j = 0; j < 7; j++) stim.push_back(r[j]);
    push_word(10'h17C); push_word(10'h2A5); push_word(10'h283);
    push_word(10'h2A5); push_word(10'h17C);
    first_v = -1; lock_edge = -1; n_str = 0;
    for (int i = 0; i < stim.size(); i++) begin
      drive_bit(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL acquire_cycle edge=%0d got=%h exp=%h", m_k, obs, exp_vec());
      end
      if (RxValid === 1'b1) begin
        $display("acquire strobe edge=%0d word=%h comma=%b locked=%b", m_k, RxParallel_10, CommaDet, Locked);
        n_checks++;
        if (m_k != 17 + 10 * n_str) begin
          n_errors++;
          $display("FAIL acquire_spacing strobe=%0d got_edge=%0d exp_edge=%0d", n_str, m_k, 17 + 10 * n_str);
        end
        if (first_v < 0) begin
          first_v = m_k;
          n_checks++;
          if (RxParallel_10 !== 10'h17C || CommaDet !== 1'b1) begin
            n_errors++;
            $display("FAIL acquire_first_word got=%h/%b exp=17c/1", RxParallel_10, CommaDet);
          end
        end
        n_str++;
      end
      if (Locked === 1'b1 && lock_edge < 0) lock_edge = m_k;
    end
    n_checks++;
    if (first_v != 17) begin
      n_errors++;
      $display("FAIL acquire_first_edge got=%0d exp=17", first_v);
    end
    n_checks++;
    if (lock_edge != 57) begin
      n_errors++;
      $display("FAIL acquire_lock_edge got=%0d exp=57", lock_edge);
    end
    $display("test_acquire done");
  endtask

  task automatic test_check_realign();
    do_reset();
    stim.delete();
    push_word(COMMA);
    push_alt(3);
    push_word(COMMA); push_word(COMMA); push_word(COMMA);
    for (int i = 0; i < stim.size(); i++) begin
      drive_bit(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL realign_cycle edge=%0d got=%h exp=%h", m_k, obs, exp_vec());
      end
      if (RxValid === 1'b1)
        $display("realign strobe edge=%0d word=%h comma=%b locked=%b", m_k, RxParallel_10, CommaDet, Locked);
      if (m_k == 21 || m_k == 22) begin
        n_checks++;
        if (RxValid !== 1'b0) begin
          n_errors++;
          $display("FAIL realign_gap edge=%0d got=%b exp=0", m_k, RxValid);
        end
      end
      if (m_k == 23) begin
        n_checks++;
        if ({RxValid, CommaDet, RxParallel_10} !== {2'b11, COMMA}) begin
          n_errors++;
          $display("FAIL realign_shift got=%b%b/%h exp=11/%h", RxValid, CommaDet, RxParallel_10, COMMA);
        end
      end
      if (m_k == 33) begin
        n_checks++;
        if ({RxValid, Locked} !== 2'b10) begin
          n_errors++;
          $display("FAIL realign_second got=%b%b exp=10", RxValid, Locked);
        end
      end
      if (m_k == 43) begin
        n_checks++;
        if ({RxValid, Locked} !== 2'b11) begin
          n_errors++;
          $display("FAIL realign_lock got=%b%b exp=11", RxValid, Locked);
        end
      end
    end
    $display("test_check_realign done");
  endtask

  task automatic test_loss_of_lock();
    do_reset();
    stim.delete();
    repeat (LOCK_N) push_word(COMMA);
    repeat (LOSS_N) push_unit();
    push_alt(10);
    push_word(COMMA);
    for (int i = 0; i < stim.size(); i++) begin
      drive_bit(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL loss_cycle edge=%0d got=%h exp=%h", m_k, obs, exp_vec());
      end
      if (RxValid === 1'b1)
        $display("loss strobe edge=%0d word=%h comma=%b locked=%b", m_k, RxParallel_10, CommaDet, Locked);
      if (m_k == 103 || m_k == 104) begin
        n_checks++;
        if (Locked !== (m_k == 103)) begin
          n_errors++;
          $display("FAIL loss_edge edge=%0d got=%b exp=%b", m_k, Locked, (m_k == 103));
        end
      end
      if (m_k > 104 && m_k < 130) begin
        n_checks++;
        if (RxValid !== 1'b0) begin
          n_errors++;
          $display("FAIL loss_quiet edge=%0d got=%b exp=0", m_k, RxValid);
        end
      end
      if (m_k == 130) begin
        n_checks++;
        if ({RxValid, CommaDet, Locked} !== 3'b110) begin
          n_errors++;
          $display("FAIL loss_rehunt got=%b%b%b exp=110", RxValid, CommaDet, Locked);
        end
      end
    end
    $display("test_loss_of_lock done");
  endtask

  task automatic test_locked_tolerance();
    do_reset();
    stim.delete();
    repeat (LOCK_N) push_word(COMMA);
    repeat (LOSS_N - 1) push_unit();
    push_word(COMMA);
    repeat (LOSS_N - 1) push_unit();
    for (int i = 0; i < stim.size(); i++) begin
      drive_bit(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL tolerance_cycle edge=%0d got=%h exp=%h", m_k, obs, exp_vec());
      end
      if (m_k >= 30) begin
        n_checks++;
        if (Locked !== 1'b1) begin
          n_errors++;
          $display("FAIL tolerance_locked edge=%0d got=%b exp=1", m_k, Locked);
        end
      end
    end
    $display("test_locked_tolerance done");
  endtask

  task automatic test_err_cnt();
    do_reset();
    stim.delete();
    repeat (LOCK_N) push_word(COMMA);
    repeat (300) begin
      push_unit();
      push_word(COMMA);
    end
    for (int i = 0; i < stim.size(); i++) begin
      drive_bit(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL errcnt_cycle edge=%0d got=%h exp=%h", m_k, obs, exp_vec());
      end
    end
    n_checks++;
    if (Locked !== 1'b1) begin
      n_errors++;
      $display("FAIL errcnt_locked got=%b exp=1", Locked);
    end
`ifdef ALIGN_ERR_CNT_EN
    n_checks++;
    if (ErrCnt !== 8'hFF) begin
      n_errors++;
      $display("FAIL errcnt_sat got=%0d exp=255", ErrCnt);
    end
    #2 Reset_n = 1'b0;
    #1;
    n_checks++;
    if (ErrCnt !== 8'h00) begin
      n_errors++;
      $display("FAIL errcnt_clear got=%0d exp=0", ErrCnt);
    end
    @(posedge BitCLK);
    #2 Reset_n = 1'b1;
    model_reset();
`endif
    $display("test_err_cnt done");
  endtask

  task automatic test_random();
    do_reset();
    stim.delete();
    while (stim.size() < 2000) begin
      case ($urandom_range(0, 3))
        0: repeat ($urandom_range(1, 12)) stim.push_back(1'($urandom));
        1: push_word(COMMA);
        2: push_word(~COMMA);
        default: push_alt($urandom_range(1, 15));
      endcase
    end
    for (int i = 0; i < stim.size(); i++) begin
      drive_bit(stim[i]);
      n_checks++;
      if (obs !== exp_vec()) begin
        n_errors++;
        $display("FAIL random_cycle edge=%0d got=%h exp=%h", m_k, obs, exp_vec());
      end
    end
    $display("test_random done");
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout simulation did not complete");
    $fatal(1, "timeout");
  end

  initial begin
    model_reset();
    test_reset();
    test_acquire();
    test_check_realign();
    test_loss_of_lock();
    test_locked_tolerance();
    test_err_cnt();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
